// File: rtl/hazard_sb_if.sv
// -----------------------------------------------------------------------------
// hazard_sb_if
// Signal bundle between the pipeline datapath/control and hazard_sb_unit.
//
// Optional feature macro: HAZARD_PERF_CNT_EN
//   When defined, three 32-bit wrapping performance counters are added
//   (perf_cache_stall, perf_use_stall, perf_flush).
//
// Signals (direction as seen by the hazard unit, modport slave):
//   icache_stall   in   fetch miss
//   dcache_stall   in   data miss
//   alu_busy       in   multi-cycle mul/div busy in E
//   src_reg        in   D-stage source registers, src n at [5n+4:5n]
//   issue_regwrite in   D instruction writes a GPR
//   issue_wreg     in   D destination register
//   issue_lat      in   back-end advances before the result is forwardable
//   exc_i          in   exception/eret flush request from E (pulse)
//   mispred_i      in   branch mispredict in E (level)
//   fwd_sel        out  per-source forward select, 0 = regfile, k = stage k-1
//   stall          out  bit0 F, bit1 D, bit(2+k) back-end stage k
//   flush          out  same indexing as stall
//   flush_pend     out  deferred exception flush is pending
// -----------------------------------------------------------------------------
interface hazard_sb_if #(
   parameter int NUM_BE  = 3,
   parameter int NUM_SRC = 2,
   parameter int LAT_W   = 2
);
   localparam int SEL_W = $clog2(NUM_BE + 1);

   logic                     icache_stall;
   logic                     dcache_stall;
   logic                     alu_busy;
   logic [NUM_SRC*5-1:0]     src_reg;
   logic                     issue_regwrite;
   logic [4:0]               issue_wreg;
   logic [LAT_W-1:0]         issue_lat;
   logic                     exc_i;
   logic                     mispred_i;
   logic [NUM_SRC*SEL_W-1:0] fwd_sel;
   logic [NUM_BE+1:0]        stall;
   logic [NUM_BE+1:0]        flush;
   logic                     flush_pend;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0]              perf_cache_stall;
   logic [31:0]              perf_use_stall;
   logic [31:0]              perf_flush;

   modport slave (
      input  icache_stall, dcache_stall, alu_busy, src_reg,
      input  issue_regwrite, issue_wreg, issue_lat, exc_i, mispred_i,
      output fwd_sel, stall, flush, flush_pend,
      output perf_cache_stall, perf_use_stall, perf_flush
   );
   modport master (
      output icache_stall, dcache_stall, alu_busy, src_reg,
      output issue_regwrite, issue_wreg, issue_lat, exc_i, mispred_i,
      input  fwd_sel, stall, flush, flush_pend,
      input  perf_cache_stall, perf_use_stall, perf_flush
   );
`else
   modport slave (
      input  icache_stall, dcache_stall, alu_busy, src_reg,
      input  issue_regwrite, issue_wreg, issue_lat, exc_i, mispred_i,
      output fwd_sel, stall, flush, flush_pend
   );
   modport master (
      output icache_stall, dcache_stall, alu_busy, src_reg,
      output issue_regwrite, issue_wreg, issue_lat, exc_i, mispred_i,
      input  fwd_sel, stall, flush, flush_pend
   );
`endif
endinterface

// File: rtl/hazard_sb_unit.sv
// -----------------------------------------------------------------------------
// hazard_sb_unit
// Latency-aware hazard and forwarding controller for an in-order pipeline
// F, D, then NUM_BE back-end stages (index 0 = E, last = W).
//
// A scoreboard shadow of every back-end stage (valid, regwrite, dest,
// remaining latency) moves in lock-step with the stall/flush vectors this
// block drives. D-stage sources are matched against it to pick a forward
// source or raise a load-use style hazard. Exceptions raised while the
// pipeline is frozen are deferred by a two-state FSM.
//
// Optional feature macro: HAZARD_PERF_CNT_EN (perf counters on the interface).
//
// Ports:
//   clk     clock
//   resetn  asynchronous active-low reset
//   bus     hazard_sb_if.slave, all pipeline control signals
// -----------------------------------------------------------------------------
module hazard_sb_unit #(
   parameter int NUM_BE  = 3,
   parameter int NUM_SRC = 2,
   parameter int LAT_W   = 2
) (
   input  logic       clk,
   input  logic       resetn,
   hazard_sb_if.slave bus
);
   localparam int SEL_W = $clog2(NUM_BE + 1);
   localparam int NST   = NUM_BE + 2;

   typedef struct packed {
      logic             vld;
      logic             rw;
      logic [4:0]       dst;
      logic [LAT_W-1:0] rem;
   } ent_t;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_PEND = 1'b1
   } state_t;

   ent_t                     r_ent [NUM_BE];
   state_t                   r_state;
   logic                     r_flush_pend;

   logic                     w_gstall;
   logic                     w_use_hz;
   logic                     w_exc_go;
   logic                     w_d_adv;
   logic [SEL_W-1:0]         w_sel [NUM_SRC];
   logic [NUM_SRC-1:0]       w_src_hz;
   logic [NUM_SRC*SEL_W-1:0] w_fwd_sel;
   logic [NST-1:0]           w_stall;
   logic [NST-1:0]           w_flush;

   function automatic logic [LAT_W-1:0] sat_dec(input logic [LAT_W-1:0] v);
      logic [LAT_W-1:0] res;
      if (v == {LAT_W{1'b0}}) begin
         res = {LAT_W{1'b0}};
      end else begin
         res = v - {{(LAT_W-1){1'b0}}, 1'b1};
      end
      return res;
   endfunction

   assign w_gstall = bus.icache_stall | bus.dcache_stall | bus.alu_busy;

   // A pending exception fires as soon as the freeze lifts; a fresh one only from RUN.
   assign w_exc_go = (bus.exc_i & ~w_gstall & (r_state == ST_RUN)) |
                     ((r_state == ST_PEND) & ~w_gstall);

   // Scoreboard lookup per source. Scanning oldest to youngest lets the
   // youngest matching writer overwrite the result, so it always wins even
   // when an older copy of the same register is already forwardable.
   always_comb begin
      w_fwd_sel = {(NUM_SRC*SEL_W){1'b0}};
      for (int n = 0; n < NUM_SRC; n++) begin
         w_sel[n]    = {SEL_W{1'b0}};
         w_src_hz[n] = 1'b0;
         for (int k = NUM_BE - 1; k >= 0; k--) begin
            if (r_ent[k].vld && r_ent[k].rw &&
                (r_ent[k].dst == bus.src_reg[5*n +: 5]) &&
                (bus.src_reg[5*n +: 5] != 5'd0)) begin
               if (r_ent[k].rem == {LAT_W{1'b0}}) begin
                  w_sel[n]    = SEL_W'(k + 1);
                  w_src_hz[n] = 1'b0;
               end else begin
                  w_sel[n]    = {SEL_W{1'b0}};
                  w_src_hz[n] = 1'b1;
               end
            end else begin
               w_sel[n]    = w_sel[n];
               w_src_hz[n] = w_src_hz[n];
            end
         end
         w_fwd_sel[SEL_W*n +: SEL_W] = w_sel[n];
      end
   end

   assign w_use_hz = |w_src_hz;

   // Stall and flush vectors; exception beats mispredict beats hazard bubble.
   always_comb begin
      w_stall = {NST{1'b0}};
      for (int k = 0; k < NUM_BE; k++) begin
         w_stall[2+k] = w_gstall;
      end
      w_stall[1] = w_gstall | w_use_hz;
      // The exception redirect must be fetched even if D is held.
      w_stall[0] = (w_gstall | w_use_hz) & ~w_exc_go;

      w_flush = {NST{1'b0}};
      if (w_exc_go) begin
         // Everything younger than W is killed; W retires.
         for (int i = 0; i <= NUM_BE; i++) begin
            w_flush[i] = 1'b1;
         end
      end else if (bus.mispred_i & ~w_gstall) begin
         w_flush[1:0] = 2'b11;
      end else if (w_use_hz & ~w_gstall) begin
         w_flush[2] = 1'b1;
      end else begin
         w_flush = {NST{1'b0}};
      end
   end

   assign w_d_adv = ~w_stall[1];

   // Scoreboard shadow: mirrors stage movement driven by w_stall/w_flush.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int k = 0; k < NUM_BE; k++) begin
            r_ent[k] <= '0;
         end
      end else begin
         if (w_flush[2]) begin
            r_ent[0] <= '0;
         end else if (w_stall[2]) begin
            r_ent[0] <= r_ent[0];
         end else if (w_d_adv) begin
            r_ent[0] <= '{vld: 1'b1, rw: bus.issue_regwrite,
                          dst: bus.issue_wreg, rem: bus.issue_lat};
         end else begin
            // D held while E moves on: E receives a bubble.
            r_ent[0] <= '0;
         end
         for (int k = 1; k < NUM_BE; k++) begin
            if (w_flush[2+k]) begin
               r_ent[k] <= '0;
            end else if (w_stall[2+k]) begin
               r_ent[k] <= r_ent[k];
            end else begin
               r_ent[k] <= '{vld: r_ent[k-1].vld, rw: r_ent[k-1].rw,
                             dst: r_ent[k-1].dst, rem: sat_dec(r_ent[k-1].rem)};
            end
         end
      end
   end

   // Deferred exception FSM with registered pending flag.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state      <= ST_RUN;
         r_flush_pend <= 1'b0;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (bus.exc_i & w_gstall) begin
                  r_state      <= ST_PEND;
                  r_flush_pend <= 1'b1;
               end else begin
                  r_state      <= ST_RUN;
                  r_flush_pend <= 1'b0;
               end
            end
            ST_PEND: begin
               if (~w_gstall) begin
                  r_state      <= ST_RUN;
                  r_flush_pend <= 1'b0;
               end else begin
                  r_state      <= ST_PEND;
                  r_flush_pend <= 1'b1;
               end
            end
            default: begin
               r_state      <= ST_RUN;
               r_flush_pend <= 1'b0;
            end
         endcase
      end
   end

   assign bus.fwd_sel    = w_fwd_sel;
   assign bus.stall      = w_stall;
   assign bus.flush      = w_flush;
   assign bus.flush_pend = r_flush_pend;

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] r_pc_cache;
   logic [31:0] r_pc_use;
   logic [31:0] r_pc_flush;

   // Wrapping event counters.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_pc_cache <= 32'd0;
         r_pc_use   <= 32'd0;
         r_pc_flush <= 32'd0;
      end else begin
         r_pc_cache <= r_pc_cache + {31'd0, (bus.icache_stall | bus.dcache_stall)};
         r_pc_use   <= r_pc_use + {31'd0, (w_use_hz & ~w_gstall)};
         r_pc_flush <= r_pc_flush + {31'd0, (w_exc_go | (bus.mispred_i & ~w_gstall))};
      end
   end

   assign bus.perf_cache_stall = r_pc_cache;
   assign bus.perf_use_stall   = r_pc_use;
   assign bus.perf_flush       = r_pc_flush;
`endif

endmodule
